// File: rtl/tile_pkg.sv
// Shared definitions for the tile pixel memory: loader states, pixel geometry
// and the byte-lane placement of the 24- and 12-bit RGB formats.
package tile_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        LAST,
        DONE
    } state_t;

    // Bit position of each incoming byte inside the assembled pixel.
    localparam int unsigned LANE24_R_LSB  = 16;
    localparam int unsigned LANE24_G_LSB  = 8;
    localparam int unsigned LANE24_B_LSB  = 0;
    localparam int unsigned LANE12_HI_LSB = 8;
    localparam int unsigned LANE12_LO_LSB = 0;

    function automatic int unsigned bytes_per_pixel(input int unsigned color_bits);
        return (color_bits == 12) ? 2 : 3;
    endfunction

endpackage

// File: rtl/pixel_packer.sv
// Collects MSB-first bytes into one pixel; pix_done/pixel are valid in the
// cycle the final byte of a pixel is accepted.
module pixel_packer
    import tile_pkg::*;
#(
    parameter int unsigned COLOR_BITS = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  accept,
    input  logic [7:0]            byte_data,
    output logic                  pix_done,
    output logic [COLOR_BITS-1:0] pixel
);

    localparam int unsigned BPP      = bytes_per_pixel(COLOR_BITS);
    localparam logic [1:0]  LAST_IDX = 2'(BPP - 1);

    logic [1:0] cnt;

    assign pix_done = accept && (cnt == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= pix_done ? '0 : cnt + 2'd1;
        end
    end

    // Only the leading bytes are held; the final byte is merged combinationally
    // so the write register can capture the pixel on the same edge.
    if (COLOR_BITS == 24) begin : g_rgb24
        logic [15:0] held;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                held <= '0;
            end else if (accept && !pix_done) begin
                held <= {held[7:0], byte_data};
            end
        end

        always_comb begin
            pixel = '0;
            pixel[LANE24_R_LSB +: 8] = held[15:8];
            pixel[LANE24_G_LSB +: 8] = held[7:0];
            pixel[LANE24_B_LSB +: 8] = byte_data;
        end
    end else begin : g_rgb12
        logic [3:0] held;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                held <= '0;
            end else if (accept && !pix_done) begin
                held <= byte_data[3:0];
            end
        end

        always_comb begin
            pixel = '0;
            pixel[LANE12_HI_LSB +: 4] = held;
            pixel[LANE12_LO_LSB +: 8] = byte_data;
        end
    end

endmodule

// File: rtl/tile_loader.sv
// Streams bytes into the tile RAM: packs pixels and writes them from a
// commanded base address through a registered synchronous write port.
module tile_loader
    import tile_pkg::*;
#(
    parameter int unsigned ADDRESS    = 13,
    parameter int unsigned COLOR_BITS = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDRESS-1:0]    base_addr,
    input  logic [ADDRESS:0]      pix_count,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  we,
    output logic [ADDRESS-1:0]    waddr,
    output logic [COLOR_BITS-1:0] wdata,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDRESS:0] ONE_LEFT = 1;

    state_t                  state, state_next;
    logic [ADDRESS-1:0]      addr;
    logic [ADDRESS:0]        remaining;
    logic                    accept;
    logic                    pix_done;
    logic [COLOR_BITS-1:0]   pixel;

    assign byte_ready = (state == LOAD);
    assign busy       = (state == LOAD) || (state == LAST);
    assign done       = (state == DONE);
    assign accept     = byte_valid && byte_ready;

    pixel_packer #(
        .COLOR_BITS(COLOR_BITS)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .accept   (accept),
        .byte_data(byte_data),
        .pix_done (pix_done),
        .pixel    (pixel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = (pix_count == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (pix_done && (remaining == ONE_LEFT)) begin
                    state_next = LAST;
                end
            end
            LAST:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            remaining <= '0;
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
        end else begin
            we <= 1'b0;
            if ((state == IDLE) && start) begin
                addr      <= base_addr;
                remaining <= pix_count;
            end
            if (pix_done) begin
                we        <= 1'b1;
                waddr     <= addr;
                wdata     <= pixel;
                addr      <= addr + ADDRESS'(1);
                remaining <= remaining - ONE_LEFT;
            end
        end
    end

endmodule

// File: tb/tb_tile_loader.sv
// Randomized bench for tile_loader: a 24-bit and a 12-bit instance share clock
// and reset and are compared against a byte-stream reference model.
module tb_tile_loader;

    localparam int unsigned AW    = 13;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst;

    logic [1:0]    start_v;
    logic [1:0]    valid_v;
    logic [AW-1:0] base_s [2];
    logic [AW:0]   cnt_s  [2];
    logic [7:0]    data_s [2];

    logic [1:0]    ready_v, we_v, busy_v, done_v;
    logic [AW-1:0] waddr24, waddr12;
    logic [23:0]   wdata24;
    logic [11:0]   wdata12;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [7:0]    stim [$];
    logic [31:0]   last_a [2];
    logic [31:0]   last_d [2];

    always #5 clk = ~clk;

    tile_loader #(.ADDRESS(AW), .COLOR_BITS(24)) u_dut24 (
        .clk(clk), .rst(rst), .start(start_v[0]), .base_addr(base_s[0]),
        .pix_count(cnt_s[0]), .byte_valid(valid_v[0]), .byte_data(data_s[0]),
        .byte_ready(ready_v[0]), .we(we_v[0]), .waddr(waddr24), .wdata(wdata24),
        .busy(busy_v[0]), .done(done_v[0])
    );

    tile_loader #(.ADDRESS(AW), .COLOR_BITS(12)) u_dut12 (
        .clk(clk), .rst(rst), .start(start_v[1]), .base_addr(base_s[1]),
        .pix_count(cnt_s[1]), .byte_valid(valid_v[1]), .byte_data(data_s[1]),
        .byte_ready(ready_v[1]), .we(we_v[1]), .waddr(waddr12), .wdata(wdata12),
        .busy(busy_v[1]), .done(done_v[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs_waddr(input int d);
        return (d == 0) ? 32'(waddr24) : 32'(waddr12);
    endfunction

    function automatic logic [31:0] obs_wdata(input int d);
        return (d == 0) ? 32'(wdata24) : 32'(wdata12);
    endfunction

    // Reference pixel i built from the byte list by the format's packing rule.
    function automatic logic [31:0] exp_pixel(input int d, input int unsigned i);
        if (d == 0)
            return (32'(stim[3*i]) << 16) | (32'(stim[3*i+1]) << 8) | 32'(stim[3*i+2]);
        return ((32'(stim[2*i]) & 32'hF) << 8) | 32'(stim[2*i+1]);
    endfunction

    task automatic fill_random(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) stim.push_back(8'($urandom));
    endtask

    task automatic check_reset_outputs(input int d, input string tag);
        check({tag, "_ready"}, 32'(ready_v[d]), 0);
        check({tag, "_we"},    32'(we_v[d]),    0);
        check({tag, "_waddr"}, obs_waddr(d),    0);
        check({tag, "_wdata"}, obs_wdata(d),    0);
        check({tag, "_busy"},  32'(busy_v[d]),  0);
        check({tag, "_done"},  32'(done_v[d]),  0);
    endtask

    task automatic run_load(input int d, input int unsigned base, input int unsigned count,
                            input int unsigned vprob, input bit chk_time, input bit ghost);
        int unsigned bpp   = (d == 0) ? 3 : 2;
        int unsigned total = count * bpp;
        int unsigned idx   = 0;
        int unsigned wr    = 0;
        int unsigned cyc   = 0;
        bit          fin   = 0;
        bit          ghosted = 0;
        bit          r;
        if (stim.size() == 0) fill_random(total);

        @(negedge clk);
        start_v[d] = 1'b1;
        base_s[d]  = AW'(base);
        cnt_s[d]   = (AW+1)'(count);
        @(negedge clk);
        start_v[d] = 1'b0;
        base_s[d]  = AW'($urandom);
        cnt_s[d]   = (AW+1)'($urandom);

        while (!fin && cyc < 20000) begin
            cyc++;
            r = ready_v[d];
            if (we_v[d]) begin
                if (wr >= count) begin
                    check("extra_we", 1, 0);
                end else begin
                    check("waddr", obs_waddr(d), (base + wr) % DEPTH);
                    check("wdata", obs_wdata(d), exp_pixel(d, wr));
                end
                wr++;
                last_a[d] = obs_waddr(d);
                last_d[d] = obs_wdata(d);
            end else begin
                check("waddr_hold", obs_waddr(d), last_a[d]);
                check("wdata_hold", obs_wdata(d), last_d[d]);
            end
            check("ready", 32'(r), 32'((count != 0) && (idx < total)));
            if (done_v[d]) begin
                check("done_busy", 32'(busy_v[d]), 0);
                check("write_count", wr, count);
                if (chk_time) check("duration", cyc, (count == 0) ? 1 : total + 2);
                fin = 1;
            end else begin
                check("busy", 32'(busy_v[d]), 1);
            end

            start_v[d] = 1'b0;
            if (ghost && !ghosted && idx == bpp + 1) begin
                start_v[d] = 1'b1;
                base_s[d]  = AW'($urandom);
                cnt_s[d]   = (AW+1)'($urandom_range(DEPTH, 1));
                ghosted    = 1;
            end
            if (r && idx < total) begin
                valid_v[d] = ($urandom_range(99) < vprob);
                data_s[d]  = valid_v[d] ? stim[idx] : 8'($urandom);
                if (valid_v[d]) idx++;
            end else begin
                valid_v[d] = 1'($urandom_range(1));
                data_s[d]  = 8'($urandom);
            end
            @(negedge clk);
        end
        if (!fin) check("done_timeout", 0, 1);

        valid_v[d] = 1'b0;
        start_v[d] = 1'b0;
        check("idle_done",  32'(done_v[d]),  0);
        check("idle_busy",  32'(busy_v[d]),  0);
        check("idle_ready", 32'(ready_v[d]), 0);
        check("idle_we",    32'(we_v[d]),    0);
        stim.delete();
    endtask

    initial begin
        rst     = 1'b1;
        start_v = '0;
        valid_v = '0;
        for (int i = 0; i < 2; i++) begin
            base_s[i] = '0;
            cnt_s[i]  = '0;
            data_s[i] = '0;
            last_a[i] = 0;
            last_d[i] = 0;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs(0, "rst24");
        check_reset_outputs(1, "rst12");
        rst = 1'b0;

        stim = '{8'hAA, 8'hBB, 8'hCC};
        run_load(0, 'h0010, 1, 100, 1, 0);

        stim = '{8'hF3, 8'h45, 8'h0A, 8'hBC};
        run_load(1, $urandom_range(DEPTH - 1), 2, 100, 1, 0);

        run_load(0, 'h1FFF, 2, 100, 1, 0);

        run_load(0, $urandom_range(DEPTH - 1), 4, 50, 0, 0);
        run_load(1, $urandom_range(DEPTH - 1), 4, 50, 0, 0);

        run_load(0, $urandom_range(DEPTH - 1), 0, 100, 1, 0);
        run_load(1, $urandom_range(DEPTH - 1), 0, 100, 1, 0);

        run_load(0, $urandom_range(DEPTH - 1), 3, 100, 1, 1);
        run_load(1, $urandom_range(DEPTH - 1), 5, 60, 0, 1);

        // Reset after two of three bytes of a pixel.
        @(negedge clk);
        start_v[0] = 1'b1; base_s[0] = 13'h0020; cnt_s[0] = 14'd1;
        @(negedge clk);
        start_v[0] = 1'b0; valid_v[0] = 1'b1; data_s[0] = 8'h11;
        @(negedge clk);
        data_s[0] = 8'h22;
        @(negedge clk);
        valid_v[0] = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_outputs(0, "midrst");
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_we", 32'(we_v[0]), 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            last_a[i] = 0;
            last_d[i] = 0;
        end
        repeat (2) begin
            @(negedge clk);
            check("post_rst_we", 32'(we_v[0]), 0);
        end
        run_load(0, 'h0005, 1, 100, 1, 0);

        for (int k = 0; k < 8; k++) begin
            run_load(int'($urandom_range(1)), $urandom_range(DEPTH - 1),
                     $urandom_range(20, 1), $urandom_range(100, 30), 0, 0);
        end

        run_load(1, $urandom_range(DEPTH - 1), DEPTH, 100, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tile_loader.md
# tile_loader

Streaming writer for the tile pixel memory. It accepts a byte stream over a valid/ready handshake and assembles each group of bytes into one `COLOR_BITS`-wide pixel. It writes each pixel through a synchronous write port into the tile RAM, starting at a commanded base address. It is the fill path for the same tile storage the renderer reads asynchronously by address, and it uses the same `ADDRESS`/`COLOR_BITS` geometry and RGB packing.

## Interface
- `ADDRESS`, 13, tile memory address width; depth is 2^ADDRESS pixels.
- `COLOR_BITS`, 24, pixel width; only 24 and 12 are supported.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle command pulse; honoured only in IDLE.
- `base_addr`  in  ADDRESS  first write address; sampled on an accepted `start`.
- `pix_count`  in  ADDRESS+1  number of pixels to load, 0..2^ADDRESS; sampled on an accepted `start`.
- `byte_valid`  in  1  input byte present.
- `byte_data`  in  8  input byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `we`  out  1  memory write strobe.
- `waddr`  out  ADDRESS  memory write address.
- `wdata`  out  COLOR_BITS  memory write data.
- `busy`  out  1  a load is in progress.
- `done`  out  1  one-cycle pulse marking load completion.

## Operation
- BPP (bytes per pixel) = 3 for COLOR_BITS=24 and 2 for COLOR_BITS=12.
- Byte order is MSB first.
  - 24-bit: bytes map to R[23:16], G[15:8], B[7:0].
  - 12-bit: the low nibble of byte 0 maps to [11:8], and byte 1 maps to [7:0]. The high nibble of byte 0 is discarded.
- A byte is accepted on a cycle where `byte_valid && byte_ready`. Bytes are not consumed otherwise, and `byte_data` is ignored when not accepted.
- FSM states:
  - IDLE: `byte_ready`=0 and `busy`=0. On `start`, latch `base_addr` and `pix_count`.
    - If `pix_count`=0, go to DONE.
    - Otherwise go to LOAD.
  - LOAD: `byte_ready`=1 and `busy`=1. The byte counter advances 0..BPP-1 on each accepted byte. Accepting byte BPP-1 completes a pixel.
    - If this is the final pixel, go to LAST.
    - Otherwise stay in LOAD.
  - LAST: `byte_ready`=0 and `busy`=1. The final write issues. Go to DONE.
  - DONE: `done`=1 and `busy`=0 for exactly one cycle, then go to IDLE.
- Write issue: the write port is registered.
  - A pixel completed in cycle N produces `we`=1, `waddr`=current address and `wdata`=assembled pixel in cycle N+1.
  - The address counter then increments.
  - `we` is otherwise 0.
  - Back-to-back pixels need no stall, because the next pixel's first byte may be accepted in cycle N+1.
- Address arithmetic is modulo 2^ADDRESS. Writing past the top address wraps to 0. This is legal and is not flagged.
- The remaining-pixel counter is ADDRESS+1 bits wide, so `pix_count`=2^ADDRESS fills the whole memory exactly once.
- `start` in any state other than IDLE is ignored. The latched parameters are not disturbed.
- Assertion of `rst`, including in the middle of a load, gives the following:
  - State returns to IDLE and all counters clear to 0.
  - The partial pixel is discarded, and no write is issued for it.

## Timing
- Reset values: `byte_ready`=0, `we`=0, `waddr`=0, `wdata`=0, `busy`=0, `done`=0.
- `busy` rises in the cycle after an accepted `start`.
- `byte_ready` also rises in that cycle if `pix_count`≠0.
- If `pix_count`=0, `done` pulses in the cycle after `start`, and `we` is never asserted.
- Latency from the last byte of a pixel to `we` is 1 cycle.
- Latency from the last write to `done` is 1 cycle.
- Minimum load time with a continuously valid stream, measured from `start` to `done`, is `pix_count`×BPP + 2 cycles.
- `byte_ready` depends only on state, not combinationally on `byte_valid`.
- `wdata` and `waddr` hold their last values when `we`=0.

## Structure
- Package `tile_pkg`, shared with the tile memory users, holds:
  - the state enum (IDLE, LOAD, LAST, DONE);
  - a constant function `bytes_per_pixel(COLOR_BITS)`;
  - the byte-lane mapping constants for the 24- and 12-bit formats.
- One sub-module, `pixel_packer`, holds the byte shift and assembly register and the byte counter.
  - It outputs `pix_done` and `pixel`.
  - `tile_loader` keeps the FSM, the address and remaining-pixel counters, and the write register.

## Test plan
- **24-bit, single pixel:** `base_addr`=0x0010, `pix_count`=1, bytes 0xAA, 0xBB, 0xCC -> one `we` with `waddr`=0x0010 and `wdata`=0xAABBCC. `done` pulses the next cycle, and `busy` falls with `done`.
- **12-bit, two pixels:** `COLOR_BITS`=12, `pix_count`=2, bytes 0xF3, 0x45, 0x0A, 0xBC -> writes 0x345 to `base_addr` and then 0xABC to `base_addr`+1.
- **Wrap-around:** `base_addr`=0x1FFF, `pix_count`=2 -> writes land at 0x1FFF and then 0x0000. Total duration is 8 cycles from `start` to `done`.
- **Backpressure:** `byte_valid` toggles randomly over 4 pixels. Required response:
  - written data and addresses match the byte order;
  - no byte is dropped or duplicated;
  - `byte_ready`=0 in IDLE, LAST and DONE.
- **Zero count and ignored start:** `pix_count`=0 -> `done` pulses 1 cycle after `start` with no `we`. A `start` pulse during LOAD changes neither the target address nor the remaining count.
- **Reset mid-pixel:** assert `rst` after 2 of the 3 bytes of a pixel -> all outputs return to reset values, and no `we` occurs. A following load of 1 pixel at 0x0005 writes only that pixel.
